// File: rtl/shiftsub_divider.sv
// Sequential restoring (shift-subtract) unsigned divider: one quotient bit per clock,
// start/done handshake matching the shift-add multiplier.
module shiftsub_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   trial;

    // Trial subtraction is one bit wider so its MSB acts as the borrow flag.
    assign trial = {r_q, q_q[WIDTH-1]} - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d = RUN;
                        dvs_d   = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = FIN;
                        q_d     = '1;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Divisor is pure data; it is always reloaded before use.
    always_ff @(posedge clk) begin
        dvs_q <= dvs_d;
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shiftsub_divider.sv
// Directed and sweep checks for shiftsub_divider at WIDTH=4 and WIDTH=16.
module tb_shiftsub_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4;
    logic [3:0]  a4, b4, q4, r4;
    logic        busy4, done4, dz4;
    logic        start16;
    logic [15:0] a16, b16, q16, r16;
    logic        busy16, done16, dz16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shiftsub_divider #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(a4), .divisor(b4),
        .quotient(q4), .remainder(r4), .busy(busy4), .done(done4), .div_by_zero(dz4)
    );

    shiftsub_divider #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(a16), .divisor(b16),
        .quotient(q16), .remainder(r16), .busy(busy16), .done(done16), .div_by_zero(dz16)
    );

    // Launch one WIDTH=4 division; cyc counts edges from the accepting edge until done is seen.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int cyc);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start4 = 1'b0; start16 = 1'b0;
        a4 = '0; b4 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({q4, r4, busy4, done4, dz4} !== 11'd0) begin
            errors++;
            $display("FAIL reset4 got q=%0d r=%0d busy=%0b done=%0b dz=%0b exp all 0", q4, r4, busy4, done4, dz4);
        end
        checks++;
        if ({q16, r16, busy16, done16, dz16} !== 35'd0) begin
            errors++;
            $display("FAIL reset16 got q=%0d r=%0d busy=%0b done=%0b dz=%0b exp all 0", q16, r16, busy16, done16, dz16);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        run4(4'd13, 4'd4, cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", cyc); end
        checks++;
        if (q4 !== 4'd3) begin errors++; $display("FAIL basic_q got %0d exp 3", q4); end
        checks++;
        if (r4 !== 4'd1) begin errors++; $display("FAIL basic_r got %0d exp 1", r4); end
        checks++;
        if (dz4 !== 1'b0) begin errors++; $display("FAIL basic_dz got %0b exp 0", dz4); end
        @(negedge clk);
        checks++;
        if ({busy4, done4} !== 2'b00) begin
            errors++; $display("FAIL basic_after busy=%0b done=%0b exp 0 0", busy4, done4);
        end
    endtask

    task automatic test_edges();
        logic [3:0] ta [4] = '{4'd15, 4'd3, 4'd0, 4'd15};
        logic [3:0] tb [4] = '{4'd1,  4'd9, 4'd5, 4'd15};
        logic [3:0] tq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
        logic [3:0] tr [4] = '{4'd0,  4'd3, 4'd0, 4'd0};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            run4(ta[i], tb[i], cyc);
            checks++;
            if (q4 !== tq[i] || r4 !== tr[i] || cyc !== 5) begin
                errors++;
                $display("FAIL edge_%0d_%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=5",
                         ta[i], tb[i], q4, r4, cyc, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        run4(4'd7, 4'd0, cyc);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", cyc); end
        checks++;
        if (dz4 !== 1'b1 || busy4 !== 1'b1) begin
            errors++; $display("FAIL dz_flags got dz=%0b busy=%0b exp 1 1", dz4, busy4);
        end
        checks++;
        if (q4 !== 4'hF || r4 !== 4'd7) begin
            errors++; $display("FAIL dz_result got q=%0d r=%0d exp q=15 r=7", q4, r4);
        end
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || dz4 !== 1'b1) begin
            errors++; $display("FAIL dz_after got busy=%0b dz=%0b exp busy=0 dz=1", busy4, dz4);
        end
        run4(4'd9, 4'd2, cyc);
        checks++;
        if (q4 !== 4'd4 || r4 !== 4'd1 || dz4 !== 1'b0) begin
            errors++; $display("FAIL dz_next got q=%0d r=%0d dz=%0b exp q=4 r=1 dz=0", q4, r4, dz4);
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic [3:0] gq = '0, gr = '0;
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd5; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done4) begin pulses++; gq = q4; gr = r4; end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
        checks++;
        if (gq !== 4'd2 || gr !== 4'd2) begin
            errors++; $display("FAIL ignore_result got q=%0d r=%0d exp q=2 r=2", gq, gr);
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        int cyc;
        @(negedge clk);
        a4 = 4'd14; b4 = 4'd3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({q4, r4, busy4, done4, dz4} !== 11'd0) begin
            errors++;
            $display("FAIL abort_state got q=%0d r=%0d busy=%0b done=%0b dz=%0b exp all 0", q4, r4, busy4, done4, dz4);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done4) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_nodone got %0d exp 0", pulses); end
        run4(4'd14, 4'd3, cyc);
        checks++;
        if (q4 !== 4'd4 || r4 !== 4'd2 || cyc !== 5) begin
            errors++; $display("FAIL abort_fresh got q=%0d r=%0d lat=%0d exp q=4 r=2 lat=5", q4, r4, cyc);
        end
    endtask

    task automatic test_sweep4();
        int a, b, eq, er, cyc;
        logic edz;
        @(negedge clk);
        start4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = i / 16; b = i % 16;
            a4 = 4'(a); b4 = 4'(b);
            eq  = (b == 0) ? 15 : a / b;
            er  = (b == 0) ? a : a % b;
            edz = (b == 0);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done4 && cyc < 12);
            checks++;
            if (done4 !== 1'b1 || q4 !== 4'(eq) || r4 !== 4'(er) || dz4 !== edz) begin
                errors++;
                $display("FAIL sweep4_%0d_%0d got done=%0b q=%0d r=%0d dz=%0b exp q=%0d r=%0d dz=%0b",
                         a, b, done4, q4, r4, dz4, eq, er, edz);
            end
        end
        start4 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random16();
        int unsigned a, b, eq, er;
        int cyc;
        logic edz;
        @(negedge clk);
        start16 = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            a = $urandom_range(0, 65535);
            b = (i % 16 == 5) ? 0 : $urandom_range(0, 65535);
            if (i % 7 == 3) b = $urandom_range(1, 40);
            a16 = 16'(a); b16 = 16'(b);
            eq  = (b == 0) ? 65535 : a / b;
            er  = (b == 0) ? a : a % b;
            edz = (b == 0);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done16 && cyc < 24);
            checks++;
            if (done16 !== 1'b1 || q16 !== 16'(eq) || r16 !== 16'(er) || dz16 !== edz) begin
                errors++;
                $display("FAIL rand16_%0d_%0d got done=%0b q=%0d r=%0d dz=%0b exp q=%0d r=%0d dz=%0b",
                         a, b, done16, q16, r16, dz16, eq, er, edz);
            end
        end
        start16 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignore_start();
        test_abort();
        test_sweep4();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
